// File: rtl/branch_predict_unit_if.sv
// rtl/branch_predict_unit_if.sv - fetch lookup, EX resolve and redirect signals of the branch predictor
interface branch_predict_unit_if #(
  parameter int ADDR_W = 32
);
  logic [ADDR_W-1:0] if_pc;
  logic              pred_taken;
  logic [ADDR_W-1:0] pred_next_pc;
  logic              res_valid;
  logic [ADDR_W-1:0] res_pc;
  logic [ADDR_W-1:0] res_imm;
  logic              res_taken;
  logic              res_pred_taken;
  logic [ADDR_W-1:0] res_pred_target;
  logic              bp_flush;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;

  modport master (
    output if_pc, res_valid, res_pc, res_imm, res_taken, res_pred_taken, res_pred_target, bp_flush,
    input  pred_taken, pred_next_pc, redirect_valid, redirect_pc
  );

  modport slave (
    input  if_pc, res_valid, res_pc, res_imm, res_taken, res_pred_taken, res_pred_target, bp_flush,
    output pred_taken, pred_next_pc, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/branch_predict_unit.sv
// rtl/branch_predict_unit.sv - direct-mapped BTB with 2-bit counters, EX-stage training and redirect
// Optional BP_STATS_EN adds stat_branches / stat_mispredicts counters.
module branch_predict_unit #(
  parameter int ADDR_W    = 32,
  parameter int ENTRIES   = 16,
  parameter int IMM_SHIFT = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  branch_predict_unit_if.slave bp
`ifdef BP_STATS_EN
  ,
  output logic [31:0]          stat_branches,
  output logic [31:0]          stat_mispredicts
`endif
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = ADDR_W - IDX_W - 2;

  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q [ENTRIES];
  logic [1:0]         ctr_q [ENTRIES];
  logic [ADDR_W-1:0]  tgt_q [ENTRIES];

  logic [IDX_W-1:0]  lk_idx;
  logic [IDX_W-1:0]  rs_idx;
  logic [TAG_W-1:0]  lk_tag;
  logic [TAG_W-1:0]  rs_tag;
  logic              lk_hit;
  logic              rs_hit;
  logic [ADDR_W-1:0] rs_seq_pc;
  logic [ADDR_W-1:0] actual_target;
  logic [ADDR_W-1:0] actual_next;
  logic              mispredict;

  always_comb begin
    lk_idx = bp.if_pc[IDX_W+1:2];
    lk_tag = bp.if_pc[ADDR_W-1:IDX_W+2];
    lk_hit = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    bp.pred_taken   = lk_hit && ctr_q[lk_idx][1];
    bp.pred_next_pc = bp.pred_taken ? tgt_q[lk_idx] : bp.if_pc + ADDR_W'(4);
  end

  // Target arithmetic wraps modulo 2^ADDR_W; carries out of the top bit are dropped.
  always_comb begin
    rs_idx        = bp.res_pc[IDX_W+1:2];
    rs_tag        = bp.res_pc[ADDR_W-1:IDX_W+2];
    rs_hit        = valid_q[rs_idx] && (tag_q[rs_idx] == rs_tag);
    rs_seq_pc     = bp.res_pc + ADDR_W'(4);
    actual_target = rs_seq_pc + (bp.res_imm << IMM_SHIFT);
    actual_next   = bp.res_taken ? actual_target : rs_seq_pc;
    mispredict    = bp.res_valid &&
                    ((bp.res_pred_taken != bp.res_taken) ||
                     (bp.res_pred_taken && bp.res_taken && (bp.res_pred_target != actual_target)));
  end

  // Flush takes priority over any same-cycle allocate or counter/target update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i] <= '0;
        ctr_q[i] <= 2'b01;
        tgt_q[i] <= '0;
      end
    end else if (bp.bp_flush) begin
      valid_q <= '0;
    end else if (bp.res_valid) begin
      if (rs_hit) begin
        if (bp.res_taken) begin
          if (ctr_q[rs_idx] != 2'b11) ctr_q[rs_idx] <= ctr_q[rs_idx] + 2'b01;
          tgt_q[rs_idx] <= actual_target;
        end else if (ctr_q[rs_idx] != 2'b00) begin
          ctr_q[rs_idx] <= ctr_q[rs_idx] - 2'b01;
        end
      end else if (bp.res_taken) begin
        valid_q[rs_idx] <= 1'b1;
        tag_q[rs_idx]   <= rs_tag;
        tgt_q[rs_idx]   <= actual_target;
        ctr_q[rs_idx]   <= 2'b10;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bp.redirect_valid <= 1'b0;
      bp.redirect_pc    <= '0;
    end else begin
      bp.redirect_valid <= mispredict;
      if (mispredict) bp.redirect_pc <= actual_next;
    end
  end

`ifdef BP_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else begin
      if (bp.res_valid) stat_branches <= stat_branches + 32'd1;
      if (mispredict) stat_mispredicts <= stat_mispredicts + 32'd1;
    end
  end
`endif
endmodule
